uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
- Byte deframer directly downstream of the 20x oversampling majority-vote stage in the GPS receive path.
- Consumes one decided line bit per bit period, as `bit_in` qualified by `bit_stb`. The oversampler drives `bit_stb` for one clk at each window decision.
- Recovers 8N1 UART frames from the GPS module's serial output.
- Presents bytes to the NMEA parser over a valid/ready handshake, with a one-entry holding register and error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first. Legal range 5..8.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- bit_in  in  1  decided line level from the oversampler (idle = 1)
- bit_stb  in  1  one-clk pulse; bit_in is valid and consumed only in this cycle
- rx_data  out  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
- frame_err  out  1  one-clk pulse: stop bit sampled 0 (or parity mismatch, see Optional Feature)
- overrun  out  1  one-clk pulse: good frame completed while the holding register was full and not being drained
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- FSM advancement:
  - Advances only in cycles with bit_stb=1.
  - Cycles with bit_stb=0 hold state, shift register and counter.
  - The handshake operates every cycle regardless of bit_stb.
- FSM states:
  - IDLE: on strobe with bit_in=0 (start bit), clear counter and go to DATA. bit_in=1 stays in IDLE.
  - DATA: on each strobe, shift bit_in into the MSB of the shift register (right shift, so the first bit lands in bit 0 after DATA_BITS shifts) and increment the counter. After the DATA_BITS-th strobe, go to STOP (or PARITY when the feature is enabled).
  - STOP, bit_in=1 (good frame): go to IDLE and deliver the byte (see holding register below).
  - STOP, bit_in=0: discard the byte, pulse frame_err, go to WAIT_IDLE.
  - WAIT_IDLE: stay until a strobe with bit_in=1, then go to IDLE. A continuous low (break) therefore produces exactly one frame_err.
- Holding register on a good frame:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data and set rx_valid=1 in the next cycle. The new byte wins over the drain.
  - Otherwise: keep the old rx_data and rx_valid, drop the new byte, pulse overrun.
- Consumption: rx_valid & rx_ready with no simultaneous load clears rx_valid next cycle. rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises exactly 1 clk after the stop-bit strobe.
- Start bits are not re-verified mid-bit. The oversampler's decided bit is trusted.
- Asynchronous reset mid-frame: partial byte discarded, FSM returns to IDLE, rx_valid cleared, any held byte lost.
- bit_stb asserted on consecutive clks is legal; each strobe is a bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and consumes one strobe.
  - Expected parity = XOR of data bits, inverted when PARITY_ODD=1.
  - On mismatch, the frame is still framed through STOP, then discarded with frame_err pulsed at the stop strobe instead of being delivered.
  - A stop=0 error takes the same path as without the feature (WAIT_IDLE).
- Undefined: no PARITY state. Frame is 8N1 with the default DATA_BITS=8; PARITY_ODD unused.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP, WAIT_IDLE)
  - the default DATA_BITS constant
  - the line idle level constant (1'b1)
- No sub-module. FSM, shift register and holding register are small and tightly coupled, so the block is one module.

Test Plan:
- Frame for 0xA5: strobes 0,1,0,1,0,0,1,0,1,1 with rx_ready=1 -> rx_valid high for 1 clk, 1 clk after the 10th strobe, rx_data=8'hA5, no error pulses.
- Two back-to-back frames 0x3C then 0xC3 with rx_ready=0 throughout -> rx_data stays 0x3C, overrun pulses once at the second stop strobe. Raising rx_ready then drains 0x3C and rx_valid goes to 0.
- Frame 0x55 with stop bit 0, then 5 more zero strobes, then 1 -> exactly one frame_err pulse, no rx_valid, busy drops after the first 1 strobe. The next valid frame 0x12 is received correctly.
- Holding 0x11 unread; frame 0x22 stop strobe coincides with rx_ready=1 -> rx_valid stays 1, rx_data=0x22, no overrun.
- Assert rst after the 4th data strobe -> all outputs 0 immediately. The following frame 0x7E is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0: frame 0x07 with parity bit 1 -> delivered. The same frame with parity bit 0 -> frame_err pulse, nothing delivered.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared state encoding and line constants for the uart_byte_rx deframer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int   DEF_DATA_BITS = 8;
  localparam logic LINE_IDLE     = 1'b1;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte deframer fed by the oversampler's decided-bit strobe; one-entry holding register.
// Optional parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_byte_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_stb,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_byte_rx: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
  end

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [3:0]           r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_shift_en;
  logic                 w_cnt_clr;
  logic                 w_good;
  logic                 w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_err;
  logic                 w_par_chk;
  logic                 w_par_exp;

  assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_chk   = 1'b0;
`endif
    if (bit_stb) begin
      unique case (r_state)
        IDLE: begin
          if (bit_in != LINE_IDLE) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          w_par_chk   = 1'b1;
          w_state_nxt = STOP;
        end
`endif
        STOP: begin
          if (bit_in == LINE_IDLE) begin
            w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            // Bad parity is still framed to the stop bit, then dropped.
            w_ferr = r_par_err;
            w_good = !r_par_err;
`else
            w_good = 1'b1;
`endif
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (bit_in == LINE_IDLE) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt   <= r_cnt + 4'd1;
        r_shift <= {bit_in, r_shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_cnt_clr) begin
      r_par_err <= 1'b0;
    end else if (w_par_chk) begin
      r_par_err <= (bit_in != w_par_exp);
    end
  end
`endif

  // A new good byte takes priority over a same-cycle drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_good && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        if (w_good) r_ovr <= 1'b1;
        if (r_valid && rx_ready) r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized bench for uart_byte_rx against a frame-level reference model.
module tb_uart_byte_rx;

  localparam int EV_NONE = 0;
  localparam int EV_GOOD = 1;
  localparam int EV_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b1;
  logic       bit_stb = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;
  int         rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit         gaps_en  = 1'b0;

  always #5 clk = ~clk;

  uart_byte_rx dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_stb  (bit_stb),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic pick_rdy();
    if (rdy_mode == 0) return 1'b0;
    if (rdy_mode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, then advance the model and compare every output.
  task automatic tick(input logic b, input logic stb, input logic rdy, input int ev,
                      input logic [7:0] byt, input logic busy_after);
    logic exp_ferr;
    logic exp_ovr;
    @(negedge clk);
    bit_in   = b;
    bit_stb  = stb;
    rx_ready = rdy;
    @(posedge clk);
    #1;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (ev == EV_GOOD) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = byt;
      end else begin
        exp_ovr = 1'b1;
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (ev == EV_ERR) exp_ferr = 1'b1;
    end
    m_busy = busy_after;
    chk("rx_valid", 32'(rx_valid), 32'(m_valid));
    chk("rx_data", 32'(rx_data), 32'(m_data));
    chk("frame_err", 32'(frame_err), 32'(exp_ferr));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic gap();
    int n;
    n = gaps_en ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, pick_rdy(), EV_NONE, 8'h00, m_busy);
  endtask

  // stop_rdy < 0 uses rdy_mode for the stop strobe, else forces that ready level.
  task automatic send_frame(input logic [7:0] byt, input logic stop, input logic par_flip,
                            input int stop_rdy);
    int   ev;
    logic r;
    tick(1'b0, 1'b1, pick_rdy(), EV_NONE, 8'h00, 1'b1);
    gap();
    for (int i = 0; i < 8; i++) begin
      tick(byt[i], 1'b1, pick_rdy(), EV_NONE, 8'h00, 1'b1);
      gap();
    end
`ifdef UART_RX_PARITY_EN
    tick((^byt) ^ par_flip, 1'b1, pick_rdy(), EV_NONE, 8'h00, 1'b1);
    gap();
    ev = !stop ? EV_ERR : (par_flip ? EV_ERR : EV_GOOD);
`else
    ev = !stop ? EV_ERR : EV_GOOD;
`endif
    r = (stop_rdy < 0) ? pick_rdy() : logic'(stop_rdy[0]);
    tick(stop, 1'b1, r, ev, byt, !stop);
  endtask

  task automatic drain();
    tick(1'b1, 1'b0, 1'b1, EV_NONE, 8'h00, m_busy);
  endtask

  initial begin
    #3;
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 0xA5, ready high: single-cycle valid pulse
    rdy_mode = 1;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    chk("a5_valid", 32'(rx_valid), 32'd1);
    drain();
    chk("a5_cleared", 32'(rx_valid), 32'd0);

    // 0x3C then 0xC3 with ready low: overrun, 0x3C kept
    rdy_mode = 0;
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    chk("ovr_kept", 32'(rx_data), 32'h3C);
    tick(1'b1, 1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
    drain();
    chk("ovr_drained", 32'(rx_valid), 32'd0);

    // 0x55 with bad stop then a break, then recovery on 0x12
    rdy_mode = 1;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, EV_NONE, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 1'b1, EV_NONE, 8'h00, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, -1);
    drain();

    // Held 0x11, 0x22 stop coincides with ready: replace, no overrun
    rdy_mode = 0;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, 1);
    chk("swap_data", 32'(rx_data), 32'h22);
    drain();

    // Reset after the 4th data strobe, then 0x7E
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b1, EV_NONE, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, EV_NONE, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_busy  = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    drain();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    drain();
`endif

    // Random traffic: gaps, random ready, occasional stop/parity errors
    rdy_mode = 2;
    gaps_en  = 1'b1;
    for (int f = 0; f < 200; f++) begin
      logic [7:0] b;
      logic       stp;
      logic       pf;
      b   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 9) != 0);
      pf  = ($urandom_range(0, 7) == 0);
      for (int k = int'($urandom_range(0, 2)); k > 0; k--)
        tick(1'b1, 1'b1, pick_rdy(), EV_NONE, 8'h00, 1'b0);
      send_frame(b, stp, pf, -1);
      if (!stp) begin
        for (int k = int'($urandom_range(0, 3)); k > 0; k--)
          tick(1'b0, 1'b1, pick_rdy(), EV_NONE, 8'h00, 1'b1);
        tick(1'b1, 1'b1, pick_rdy(), EV_NONE, 8'h00, 1'b0);
      end
      gap();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
